// File: rtl/mult_div_pkg.sv
// Shared types and constants for the multicycle multiply/divide sequencer.
// The enum encodings of op_t match the 2-bit `op` command from the control unit.
package mult_div_pkg;

    localparam int MD_ITER = 32;

    typedef enum logic [1:0] {
        MULT  = 2'b00,
        MULTU = 2'b01,
        DIV   = 2'b10,
        DIVU  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } md_state_t;

    function automatic logic op_is_div(input op_t op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input op_t op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mult_div_step.sv
// One iteration of the shared datapath: shift-add multiply or restoring divide
// step on the {upper, lower} register pair. Purely combinational.
module mult_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_upper,
    input  logic [WIDTH-1:0] i_lower,
    input  logic [WIDTH-1:0] i_operand,
    input  logic             i_is_div,
    output logic [WIDTH-1:0] o_upper,
    output logic [WIDTH-1:0] o_lower
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH+1:0] w_diff;
    logic             w_fits;

    always_comb begin
        w_sum     = {1'b0, i_upper} + {1'b0, i_operand};
        w_shifted = {i_upper, i_lower[WIDTH-1]};
        w_diff    = {1'b0, w_shifted} - {2'b00, i_operand};
        // The shifted remainder is below twice the divisor, so a non-negative
        // difference always fits in WIDTH bits.
        w_fits    = (w_diff[WIDTH+1:WIDTH] == 2'b00);

        o_upper = i_upper;
        o_lower = i_lower;
        if (i_is_div) begin
            if (w_fits) begin
                o_upper = w_diff[WIDTH-1:0];
                o_lower = {i_lower[WIDTH-2:0], 1'b1};
            end else begin
                o_upper = w_shifted[WIDTH-1:0];
                o_lower = {i_lower[WIDTH-2:0], 1'b0};
            end
        end else if (i_lower[0]) begin
            o_upper = w_sum[WIDTH:1];
            o_lower = {w_sum[0], i_lower[WIDTH-1:1]};
        end else begin
            o_upper = {1'b0, i_upper[WIDTH-1:1]};
            o_lower = {i_upper[0], i_lower[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_seq.sv
// Multicycle MULT/MULTU/DIV/DIVU sequencer returning a 64-bit result in HI/LO.
// state | meaning
// IDLE  | waiting for start; operand magnitudes and result signs latched on accept
// RUN   | one datapath iteration per cycle, WIDTH iterations
// FIX   | apply latched signs, write hi/lo
// DONE  | done pulse (div_zero too on divide-by-zero), back to IDLE
module mult_div_seq
    import mult_div_pkg::*;
#(
    parameter int WIDTH = MD_ITER
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = 6;

    md_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_div;
    logic             r_neg_lo;
    logic             r_neg_hi;
    logic [WIDTH-1:0] r_upper;
    logic [WIDTH-1:0] r_lower;
    logic [WIDTH-1:0] r_operand;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;
    logic             r_done;
    logic             r_div_zero;

    op_t              w_op;
    logic             w_is_div;
    logic             w_is_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_step_upper;
    logic [WIDTH-1:0] w_step_lower;
    logic [2*WIDTH-1:0] w_prod_neg;

    always_comb begin
        w_op        = op_t'(op);
        w_is_div    = op_is_div(w_op);
        w_is_signed = op_is_signed(w_op);
        w_a_neg     = w_is_signed & a[WIDTH-1];
        w_b_neg     = w_is_signed & b[WIDTH-1];
        w_a_mag     = w_a_neg ? -a : a;
        w_b_mag     = w_b_neg ? -b : b;
        w_prod_neg  = -{r_upper, r_lower};
    end

    mult_div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .i_upper  (r_upper),
        .i_lower  (r_lower),
        .i_operand(r_operand),
        .i_is_div (r_is_div),
        .o_upper  (w_step_upper),
        .o_lower  (w_step_lower)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_is_div   <= 1'b0;
            r_neg_lo   <= 1'b0;
            r_neg_hi   <= 1'b0;
            r_upper    <= '0;
            r_lower    <= '0;
            r_operand  <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_is_div <= w_is_div;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_upper  <= '0;
                        r_neg_lo <= w_a_neg ^ w_b_neg;
                        r_neg_hi <= w_is_div & w_a_neg;
                        // Multiply shifts the multiplier out of lower; divide
                        // shifts the dividend out of lower into the remainder.
                        if (w_is_div) begin
                            r_lower   <= w_a_mag;
                            r_operand <= w_b_mag;
                        end else begin
                            r_lower   <= w_b_mag;
                            r_operand <= w_a_mag;
                        end
                        if (w_is_div && (b == '0)) begin
                            r_state    <= DONE;
                            r_done     <= 1'b1;
                            r_div_zero <= 1'b1;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_upper <= w_step_upper;
                    r_lower <= w_step_lower;
                    r_cnt   <= r_cnt + 6'd1;
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    if (!r_is_div && r_neg_lo) begin
                        r_hi <= w_prod_neg[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_neg[WIDTH-1:0];
                    end else begin
                        r_hi <= r_neg_hi ? -r_upper : r_upper;
                        r_lo <= r_neg_lo ? -r_lower : r_lower;
                    end
                    r_done  <= 1'b1;
                    r_state <= DONE;
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: doc/mult_div_seq.md
# mult_div_seq

Multicycle multiply/divide sequencer for the MIPS multicycle core. It accepts a one-cycle start command from the main control unit with two 32-bit operands (register file outputs A and B). It iterates a shift-add or shift-subtract datapath for 32 cycles and returns a 64-bit result into HI/LO. The control unit holds in a wait state while `busy` is high and advances on `done`.

## Interface
Parameters:
- `WIDTH`, 32, operand width; iteration count equals `WIDTH`.

Ports:
- `clock` in 1: single clock, all state updates on rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `start` in 1: command strobe, sampled only in IDLE.
- `op` in 2: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- `a` in 32: rs value (multiplicand / dividend).
- `b` in 32: rt value (multiplier / divisor).
- `busy` out 1: high from the cycle after start is accepted until `done` deasserts.
- `done` out 1: one-cycle pulse; HI/LO are valid from this cycle on.
- `div_zero` out 1: high together with `done` when a DIV/DIVU had `b == 0`.
- `hi` out 32: product[63:32] or remainder.
- `lo` out 32: product[31:0] or quotient.

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE, `start` = 1:
  - Latch `op` and the magnitudes of `a` and `b`. Magnitude is the raw value for unsigned ops and for non-negative signed operands; otherwise it is the two's complement.
  - Latch the result sign:
    - MULT: sign(a) XOR sign(b).
    - DIV quotient: sign(a) XOR sign(b).
    - DIV remainder: sign(a).
  - Clear the 6-bit iteration counter.
  - Go to RUN. Exception: DIV/DIVU with `b == 0` goes directly to DONE with `div_zero` = 1 and `hi`/`lo` unchanged.
- RUN, one iteration per cycle, counter increments:
  - Multiply: 64-bit {acc, mplier} register; add the multiplicand to the upper 33 bits when mplier[0] = 1, then shift right by 1.
  - Divide: restoring. Shift {rem, quot} left by 1; trial subtract the divisor from rem; when the result is non-negative, keep it and set quot[0] = 1.
  - Leave RUN after counter = WIDTH-1, to FIX.
- FIX:
  - Apply the latched signs with two's complement negation. Signed multiply negates the 64-bit product; signed divide negates quotient and remainder independently.
  - Write `hi`/`lo`, go to DONE.
- DONE: assert `done` for one cycle, then go to IDLE.
- `start` asserted in any state other than IDLE is ignored. There is no queueing.
- `hi`/`lo` hold their value until the next successful completion. A divide-by-zero does not modify them.
- Signed DIV of 0x80000000 by 0xFFFFFFFF: `lo` = 0x80000000, `hi` = 0. No trap is raised.
- Remainder sign follows the dividend. Quotient truncates toward zero.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `div_zero` 0, `hi` 0, `lo` 0, internal registers 0.
- Start accepted at edge E0. RUN occupies edges E1..E32. FIX result is written at edge E33, with DONE entered on the same edge. `done` is high in the cycle following E33, and the block is in IDLE after E34.
- Normal operation: 34 cycles from accept to `done`.
- Divide-by-zero: `done` and `div_zero` are high in the cycle after E0.
- `busy` is high in every non-IDLE state, DONE included.
- A new `start` can be accepted on the edge that leaves DONE only if sampled in IDLE. The earliest back-to-back accept is therefore E35.
- Reset asserted mid-operation aborts immediately. No `done` pulse occurs and `hi`/`lo` return to 0.
- Operands are sampled only at E0. Changes on `a`/`b` afterwards have no effect.

## Structure
- Package `mult_div_pkg`:
  - `op_t` enum with values MULT, MULTU, DIV, DIVU.
  - `md_state_t` enum with values IDLE, RUN, FIX, DONE.
  - Localparam `MD_ITER` = 32.
- Sub-module `mult_div_step`: combinational single-iteration datapath. Input is {upper, lower, operand, is_div}; output is the next {upper, lower}.
- `mult_div_seq` holds the FSM, counter, sign latches, and HI/LO registers.
- Integration: the control unit adds a wait state that loops on `!done`. MFHI/MFLO read `hi`/`lo` through an extended MemparaReg select.

## Test plan
- MULT a=0xFFFFFFFE (-2), b=3 -> `done` at cycle 34; `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFFA.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> `hi` = 0xFFFFFFFE, `lo` = 0x00000001.
- DIV a=-7 (0xFFFFFFF9), b=2 -> `lo` = 0xFFFFFFFD (-3), `hi` = 0xFFFFFFFF (-1). Also DIVU 100/7 -> `lo` = 14, `hi` = 2.
- DIV b=0 with prior `hi`/`lo` = 5/6 -> `done` and `div_zero` high one cycle after accept; `hi`/`lo` stay 5/6.
- `start` pulsed during RUN with different operands -> ignored; the original result completes at cycle 34 and `busy` never drops early.
- Reset pulled low at cycle 10 of a MULT -> outputs 0 immediately, no `done`. A fresh start after release completes correctly in 34 cycles.
